// File: rtl/binary_acc_pkg.sv
// Shared types and default widths for the binary_acc product accumulator.
// Optional saturation is selected with macro BINARY_ACC_SAT_EN (see binary_acc_sat).
package binary_acc_pkg;

    localparam int DEF_P_W   = 17;
    localparam int DEF_ACC_W = 20;
    localparam int DEF_LEN   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/binary_acc_if.sv
// Product-in / frame-result-out handshake bundle for binary_acc_17_bi.
// master = producer/consumer side, slave = the accumulator.
interface binary_acc_if
    import binary_acc_pkg::*;
#(
    parameter int P_W   = DEF_P_W,
    parameter int ACC_W = DEF_ACC_W
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [P_W-1:0]   P;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] SUM;
    logic                    OVF;

    modport master (
        output in_valid, P, out_ready,
        input  in_ready, out_valid, SUM, OVF
    );

    modport slave (
        input  in_valid, P, out_ready,
        output in_ready, out_valid, SUM, OVF
    );
endinterface

// File: rtl/binary_acc_sat.sv
// Combinational add of a sign-extended product into the accumulator with overflow detect.
// BINARY_ACC_SAT_EN defined: out-of-range sums clamp; undefined: they wrap modulo 2^ACC_W.
module binary_acc_sat
    import binary_acc_pkg::*;
#(
    parameter int P_W   = DEF_P_W,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic signed [ACC_W-1:0] acc,
    input  logic signed [P_W-1:0]   p,
    input  logic                    load,
    output logic signed [ACC_W-1:0] sum,
    output logic                    ovf
);

    logic signed [ACC_W:0] base;
    logic signed [ACC_W:0] p_ext;
    logic signed [ACC_W:0] wide;

`ifdef BINARY_ACC_SAT_EN
    function automatic logic signed [ACC_W-1:0] fold(input logic signed [ACC_W:0] w,
                                                     input logic out_of_range);
        if (!out_of_range)
            return w[ACC_W-1:0];
        // The extra top bit holds the true sign of the unbounded sum.
        return w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    endfunction
`else
    function automatic logic signed [ACC_W-1:0] fold(input logic signed [ACC_W:0] w,
                                                     input logic out_of_range);
        return out_of_range ? w[ACC_W-1:0] : w[ACC_W-1:0];
    endfunction
`endif

    always_comb begin
        base  = load ? '0 : {acc[ACC_W-1], acc};
        p_ext = {{(ACC_W+1-P_W){p[P_W-1]}}, p};
        wide  = base + p_ext;
        ovf   = wide[ACC_W] ^ wide[ACC_W-1];
        sum   = fold(wide, ovf);
    end

endmodule

// File: rtl/binary_acc_17_bi.sv
// Frame accumulator: sums LEN signed products per frame, presents SUM/OVF until released.
// Overflow handling (clamp vs wrap) is chosen by macro BINARY_ACC_SAT_EN in binary_acc_sat.
module binary_acc_17_bi
    import binary_acc_pkg::*;
#(
    parameter int P_W   = DEF_P_W,
    parameter int ACC_W = DEF_ACC_W,
    parameter int LEN   = DEF_LEN
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    binary_acc_if.slave  bus
);

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    ovf_q, ovf_d;

    logic                    accept;
    logic                    release_res;
    logic signed [ACC_W-1:0] add_sum;
    logic                    add_ovf;

    assign bus.in_ready  = (state_q != DONE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.SUM       = acc_q;
    assign bus.OVF       = ovf_q;

    assign accept      = en & bus.in_valid & bus.in_ready;
    assign release_res = en & bus.out_valid & bus.out_ready;

    // First product of a frame is loaded (base 0), later ones are added.
    binary_acc_sat #(
        .P_W   (P_W),
        .ACC_W (ACC_W)
    ) u_sat (
        .acc  (acc_q),
        .p    (bus.P),
        .load (state_q == IDLE),
        .sum  (add_sum),
        .ovf  (add_ovf)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d   = add_sum;
                    ovf_d   = add_ovf;
                    cnt_d   = 8'd1;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d = add_sum;
                    ovf_d = ovf_q | add_ovf;
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == 8'(LEN - 1))
                        state_d = DONE;
                end
            end
            DONE: begin
                if (release_res)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // en gates accept/release, so the next-state values already hold when en is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_binary_acc_17_bi.sv
// Directed, table-driven bench for binary_acc_17_bi (honours BINARY_ACC_SAT_EN for expectations).
module tb_binary_acc_17_bi;
    import binary_acc_pkg::*;

    localparam int P_W   = 17;
    localparam int ACC_W = 20;
    localparam int LEN   = 16;

    logic clk = 1'b0;
    logic rst;
    logic en;

    always #5 clk = ~clk;

    binary_acc_if #(.P_W(P_W), .ACC_W(ACC_W)) bus ();

    binary_acc_17_bi #(.P_W(P_W), .ACC_W(ACC_W), .LEN(LEN)) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .bus (bus)
    );

    int checks = 0;
    int passed = 0;

    typedef struct {
        int start;
        int step;
        int sum_wrap;
        int sum_sat;
        bit ovf;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feeds LEN products start + i*step; optional 3-cycle en-low gap before product gap_at.
    task automatic run_frame(input int start, input int step, input int gap_at);
        for (int i = 0; i < LEN; i++) begin
            if (i == gap_at) begin
                en           = 1'b0;
                bus.in_valid = 1'b1;
                bus.P        = 17'sd999;
                repeat (3) tick();
                chk("en_gap_out_valid", longint'(bus.out_valid), 0);
                chk("en_gap_in_ready", longint'(bus.in_ready), 1);
                en = 1'b1;
            end
            bus.in_valid = 1'b1;
            bus.P        = P_W'(start + i * step);
            tick();
            if (i == LEN - 2)
                chk("out_valid_before_last", longint'(bus.out_valid), 0);
        end
        bus.in_valid = 1'b0;
        chk("out_valid_after_last", longint'(bus.out_valid), 1);
    endtask

    initial begin
        int exp_sum;

        vecs[0] = '{start: 1,      step: 1, sum_wrap: 136, sum_sat: 136,     ovf: 1'b0};
        vecs[1] = '{start: 65535,  step: 0, sum_wrap: -16, sum_sat: 524287,  ovf: 1'b1};
        vecs[2] = '{start: -65536, step: 0, sum_wrap: 0,   sum_sat: -524288, ovf: 1'b1};
        vecs[3] = '{start: -1,     step: 0, sum_wrap: -16, sum_sat: -16,     ovf: 1'b0};
        vecs[4] = '{start: -8,     step: 1, sum_wrap: -8,  sum_sat: -8,      ovf: 1'b0};

        rst           = 1'b1;
        en            = 1'b1;
        bus.in_valid  = 1'b0;
        bus.P         = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_out_valid", longint'(bus.out_valid), 0);
        chk("reset_in_ready", longint'(bus.in_ready), 1);
        chk("reset_sum", longint'(bus.SUM), 0);
        chk("reset_ovf", longint'(bus.OVF), 0);

        for (int v = 0; v < 5; v++) begin
`ifdef BINARY_ACC_SAT_EN
            exp_sum = vecs[v].sum_sat;
`else
            exp_sum = vecs[v].sum_wrap;
`endif
            bus.out_ready = 1'b1;
            run_frame(vecs[v].start, vecs[v].step, -1);
            chk($sformatf("vec%0d_sum", v), longint'(bus.SUM), longint'(exp_sum));
            chk($sformatf("vec%0d_ovf", v), longint'(bus.OVF), longint'(vecs[v].ovf));
            tick();
            chk($sformatf("vec%0d_released", v), longint'(bus.out_valid), 0);
        end

        // Back-pressure: result held, no product accepted while waiting or in the release cycle.
        bus.out_ready = 1'b0;
        run_frame(1, 1, -1);
        bus.in_valid = 1'b1;
        bus.P        = 17'sd100;
        repeat (5) begin
            tick();
            chk("bp_in_ready", longint'(bus.in_ready), 0);
            chk("bp_out_valid", longint'(bus.out_valid), 1);
            chk("bp_sum", longint'(bus.SUM), 136);
        end
        bus.out_ready = 1'b1;
        tick();
        chk("bp_release_out_valid", longint'(bus.out_valid), 0);
        chk("bp_release_in_ready", longint'(bus.in_ready), 1);
        run_frame(1, 1, -1);
        chk("bp_next_frame_sum", longint'(bus.SUM), 136);
        tick();

        // en low mid-frame freezes everything; the frame result is unchanged.
        bus.out_ready = 1'b1;
        run_frame(1, 1, 5);
        chk("en_gap_sum", longint'(bus.SUM), 136);
        chk("en_gap_ovf", longint'(bus.OVF), 0);
        tick();

        // en low in DONE blocks release.
        bus.out_ready = 1'b0;
        run_frame(2, 0, -1);
        chk("done_sum", longint'(bus.SUM), 32);
        en            = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("en_low_done_hold", longint'(bus.out_valid), 1);
        en = 1'b1;
        tick();
        chk("en_high_done_release", longint'(bus.out_valid), 0);

        // Reset mid-ACCUM after OVF has been set discards the frame.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            bus.in_valid = 1'b1;
            bus.P        = 17'sd65535;
            tick();
        end
        chk("pre_reset_ovf", longint'(bus.OVF), 1);
        rst = 1'b1;
        tick();
        tick();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        chk("midrst_out_valid", longint'(bus.out_valid), 0);
        chk("midrst_in_ready", longint'(bus.in_ready), 1);
        chk("midrst_sum", longint'(bus.SUM), 0);
        chk("midrst_ovf", longint'(bus.OVF), 0);

        bus.out_ready = 1'b1;
        run_frame(-3, 0, -1);
        chk("post_reset_sum", longint'(bus.SUM), -48);
        chk("post_reset_ovf", longint'(bus.OVF), 0);
        tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
